// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Lets the core's instruction-fetch port and its data load/store port share
//   one single-port synchronous memory. Each requester uses a req/ack
//   handshake, and the arbiter runs one memory transaction at a time.
//   By default data has priority. A starvation counter forces a fetch grant
//   after STARVE_LIM consecutive data grants made while fetch was waiting.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, contended grants alternate between the
//   two requesters and the starvation counter is held at zero.
//
// Parameters:
//   AW         byte address width (passed through unchanged)
//   DW         data width
//   MEM_LAT    memory read latency, m_en to valid m_rdata (1..7)
//   STARVE_LIM data grants allowed while fetch waits (1..15)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_req/i_addr              fetch request and address
//   i_rdata/i_ack             fetched word (held) and completion pulse
//   d_req/d_we/d_mask/d_addr/d_wdata
//                             data request, store flag, byte mask, operands
//   d_rdata/d_ack             load data (held) and completion pulse
//   m_en/m_we/m_mask/m_addr/m_wdata
//                             memory strobe and request fields
//   m_rdata                   memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_mask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [3:0]    m_mask,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LatLoadC   = 3'(MEM_LAT - 1);
  localparam logic [3:0] StarveLimC = 4'(STARVE_LIM);

  state_t        state_q;
  logic          grantFetch_q;
  logic          we_q;
  logic [3:0]    mask_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] iRdata_q;
  logic [DW-1:0] dRdata_q;
  logic          mEn_q;
  logic          mWe_q;
  logic          iAck_q;
  logic          dAck_q;
  logic [2:0]    latCnt_q;
  logic [3:0]    starveCnt_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic          lastFetch_q;
`endif

  logic          anyReq_d;
  logic          fetchWins_d;
  logic [3:0]    starveCnt_d;

  // Winner selection for the IDLE decision, and the starvation count that
  // the decision would leave behind. Only used when a grant is made.
  always_comb begin
    anyReq_d = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
    fetchWins_d = i_req & (~d_req | ~lastFetch_q);
    starveCnt_d = 4'd0;
`else
    fetchWins_d = i_req & (~d_req | (starveCnt_q == StarveLimC));
    starveCnt_d = starveCnt_q;
    if (fetchWins_d || !i_req) begin
      starveCnt_d = 4'd0;
    end else if (starveCnt_q != StarveLimC) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
`endif
  end

  // Transaction FSM. The memory strobe and both acks are registered and are
  // set on the transition into the state in which they must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grantFetch_q <= 1'b0;
      we_q         <= 1'b0;
      mask_q       <= 4'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      iRdata_q     <= '0;
      dRdata_q     <= '0;
      mEn_q        <= 1'b0;
      mWe_q        <= 1'b0;
      iAck_q       <= 1'b0;
      dAck_q       <= 1'b0;
      latCnt_q     <= 3'd0;
      starveCnt_q  <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
      // Starting at "fetch granted last" makes the first contended grant data.
      lastFetch_q  <= 1'b1;
`endif
    end else begin
      mEn_q  <= 1'b0;
      mWe_q  <= 1'b0;
      iAck_q <= 1'b0;
      dAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            grantFetch_q <= fetchWins_d;
            starveCnt_q  <= starveCnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            lastFetch_q  <= fetchWins_d;
`endif
            mEn_q        <= 1'b1;
            state_q      <= ISSUE;
            if (fetchWins_d) begin
              addr_q <= i_addr;
              we_q   <= 1'b0;
              mask_q <= 4'b0;
            end else begin
              addr_q  <= d_addr;
              we_q    <= d_we;
              mask_q  <= d_we ? d_mask : 4'b0;
              wdata_q <= d_wdata;
              mWe_q   <= d_we;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= DONE;
            iAck_q  <= grantFetch_q;
            dAck_q  <= ~grantFetch_q;
          end else begin
            latCnt_q <= LatLoadC;
            if (LatLoadC == 3'd0) begin
              state_q <= DONE;
              iAck_q  <= grantFetch_q;
              dAck_q  <= ~grantFetch_q;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // Leaving on a count of one means the counter reaches zero exactly
          // as DONE is entered, which is when m_rdata becomes valid.
          latCnt_q <= latCnt_q - 3'd1;
          if (latCnt_q == 3'd1) begin
            state_q <= DONE;
            iAck_q  <= grantFetch_q;
            dAck_q  <= ~grantFetch_q;
          end
        end
        DONE: begin
          if (!we_q) begin
            if (grantFetch_q) begin
              iRdata_q <= m_rdata;
            end else begin
              dRdata_q <= m_rdata;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is first valid in the DONE cycle, alongside the ack. The data
  // is forwarded straight from memory in that cycle and then held in the
  // capture register.
  always_comb begin
    i_rdata = iRdata_q;
    d_rdata = dRdata_q;
    if (iAck_q) begin
      i_rdata = m_rdata;
    end
    if (dAck_q && !we_q) begin
      d_rdata = m_rdata;
    end
  end

  assign i_ack   = iAck_q;
  assign d_ack   = dAck_q;
  assign m_en    = mEn_q;
  assign m_we    = mWe_q;
  assign m_mask  = mask_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench uses two instances:
//   dutA: MEM_LAT=1, STARVE_LIM=4, backed by a byte-maskable word memory
//   dutB: MEM_LAT=3, backed by a 3-stage pipe that returns {16'hC0DE, addr}
// Outputs are sampled on the falling edge. Inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    logic        isFetch;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  expMask;
    logic [31:0] expRdata;
  } vec_t;

  int numChecks = 0;
  int numFail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iRdata;
  logic        iAck;
  logic        dReq;
  logic        dWe;
  logic [3:0]  dMask;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [31:0] dRdata;
  logic        dAck;
  logic        mEn;
  logic        mWe;
  logic [3:0]  mMask;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mRdata;

  // Instance B signals
  logic        rstB;
  logic        iReqB;
  logic [31:0] iAddrB;
  logic [31:0] iRdataB;
  logic        iAckB;
  logic        dReqB;
  logic        dWeB;
  logic [3:0]  dMaskB;
  logic [31:0] dAddrB;
  logic [31:0] dWdataB;
  logic [31:0] dRdataB;
  logic        dAckB;
  logic        mEnB;
  logic        mWeB;
  logic [3:0]  mMaskB;
  logic [31:0] mAddrB;
  logic [31:0] mWdataB;
  logic [31:0] mRdataB;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) dutA (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata), .i_ack(iAck),
    .d_req(dReq), .d_we(dWe), .d_mask(dMask), .d_addr(dAddr),
    .d_wdata(dWdata), .d_rdata(dRdata), .d_ack(dAck),
    .m_en(mEn), .m_we(mWe), .m_mask(mMask), .m_addr(mAddr),
    .m_wdata(mWdata), .m_rdata(mRdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_LIM(4)) dutB (
    .clk(clk), .rst(rstB),
    .i_req(iReqB), .i_addr(iAddrB), .i_rdata(iRdataB), .i_ack(iAckB),
    .d_req(dReqB), .d_we(dWeB), .d_mask(dMaskB), .d_addr(dAddrB),
    .d_wdata(dWdataB), .d_rdata(dRdataB), .d_ack(dAckB),
    .m_en(mEnB), .m_we(mWeB), .m_mask(mMaskB), .m_addr(mAddrB),
    .m_wdata(mWdataB), .m_rdata(mRdataB)
  );

  // Unified memory for instance A: 256 words, byte-masked writes, one-cycle
  // synchronous read. Word 4 (byte address 0x10) holds an instruction.
  logic [31:0] memA [0:255] = '{4: 32'h0010_0093, default: 32'h0};
  logic [31:0] rdA = 32'h0;
  logic [31:0] merged;
  always @(posedge clk) begin
    if (mEn) begin
      if (mWe) begin
        merged = memA[mAddr[9:2]];
        for (int b = 0; b < 4; b++) begin
          if (mMask[b]) merged[8*b +: 8] = mWdata[8*b +: 8];
        end
        memA[mAddr[9:2]] <= merged;
      end else begin
        rdA <= memA[mAddr[9:2]];
      end
    end
  end
  assign mRdata = rdA;

  // Memory for instance B: three-cycle read pipe with address-derived data.
  logic [31:0] pipeB [0:2];
  always @(posedge clk) begin
    pipeB[0] <= mEnB ? {16'hC0DE, mAddrB[15:0]} : 32'h0;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign mRdataB = pipeB[2];

  // Compares one sampled value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFail++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Runs one uncontended transaction on instance A. The task is entered on a
  // falling edge with the FSM idle, and it returns on the falling edge of
  // the next idle cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.isFetch) begin
      iReq  = 1'b1;
      iAddr = v.addr;
    end else begin
      dReq   = 1'b1;
      dWe    = v.we;
      dMask  = v.mask;
      dAddr  = v.addr;
      dWdata = v.wdata;
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d m_en", idx), 32'(mEn), 32'd1);
    checkOutput($sformatf("v%0d m_addr", idx), mAddr, v.addr);
    checkOutput($sformatf("v%0d m_we", idx), 32'(mWe), 32'(v.we));
    checkOutput($sformatf("v%0d m_mask", idx), 32'(mMask), 32'(v.expMask));
    if (v.we) checkOutput($sformatf("v%0d m_wdata", idx), mWdata, v.wdata);
    @(negedge clk);
    checkOutput($sformatf("v%0d ack", idx), 32'(v.isFetch ? iAck : dAck), 32'd1);
    checkOutput($sformatf("v%0d otherAck", idx), 32'(v.isFetch ? dAck : iAck), 32'd0);
    checkOutput($sformatf("v%0d m_en off", idx), 32'({mEn, mWe}), 32'd0);
    checkOutput($sformatf("v%0d m_addr hold", idx), mAddr, v.addr);
    if (!v.we) begin
      checkOutput($sformatf("v%0d rdata", idx), v.isFetch ? iRdata : dRdata, v.expRdata);
    end
    iReq = 1'b0;
    dReq = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("v%0d ack clear", idx), 32'({iAck, dAck}), 32'd0);
    if (!v.we) begin
      checkOutput($sformatf("v%0d rdata held", idx), v.isFetch ? iRdata : dRdata, v.expRdata);
    end
  endtask

  vec_t vecs [0:10];

  initial begin
    int   got;
    int   dualCnt;
    int   ackCnt;
    int   ackCycle;
    logic expFetch;

    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         4'b0000, 32'h0010_0093};
    vecs[1]  = '{1'b0, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,         4'b0000, 32'h0000_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 4'b1100, 32'h0000_0104, 32'h1234_5678, 4'b1100, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         4'b0000, 32'h1234_0000};
    vecs[5]  = '{1'b1, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         4'b0000, 32'h1234_0000};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'b0000, 32'h0000_0108, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 1'b1, 4'b0100, 32'h0000_0100, 32'h00AB_0000, 4'b0100, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,         4'b0000, 32'h00AB_BEEF};
    vecs[10] = '{1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         4'b0000, 32'h0010_0093};

    rst = 1'b1;  iReq = 1'b0;  iAddr = 32'h0;  dReq = 1'b0;  dWe = 1'b0;
    dMask = 4'b0;  dAddr = 32'h0;  dWdata = 32'h0;
    rstB = 1'b1; iReqB = 1'b0; iAddrB = 32'h0; dReqB = 1'b0; dWeB = 1'b0;
    dMaskB = 4'b0; dAddrB = 32'h0; dWdataB = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset flags", 32'({iAck, dAck, mEn, mWe, mMask}), 32'd0);
    checkOutput("reset i_rdata", iRdata, 32'h0);
    checkOutput("reset d_rdata", dRdata, 32'h0);
    checkOutput("reset m_addr", mAddr, 32'h0);
    checkOutput("reset m_wdata", mWdata, 32'h0);
    rst  = 1'b0;
    rstB = 1'b0;

    for (int k = 0; k <= 10; k++) applyStimulus(vecs[k], k);

    // Both requesters held continuously: check the grant order, one ack per
    // transaction, and that the two acks are never high together.
    iReq = 1'b1; iAddr = 32'h10;
    dReq = 1'b1; dWe = 1'b0; dMask = 4'b0; dAddr = 32'h100;
    dualCnt = 0;
    for (int g = 0; g < 10; g++) begin
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        @(negedge clk);
        if (iAck && dAck) dualCnt++;
        if (iAck || dAck) got = 1;
      end
      checkOutput($sformatf("grant%0d seen", g), 32'(got), 32'd1);
`ifdef ARB_ROUND_ROBIN_EN
      expFetch = (g % 2 == 1);
`else
      expFetch = (g == 4 || g == 9);
`endif
      checkOutput($sformatf("grant%0d winner", g), 32'(iAck), 32'(expFetch));
      if (iAck) checkOutput($sformatf("grant%0d i_rdata", g), iRdata, 32'h0010_0093);
      if (dAck) checkOutput($sformatf("grant%0d d_rdata", g), dRdata, 32'h00AB_BEEF);
    end
    iReq = 1'b0;
    dReq = 1'b0;
    checkOutput("dual acks", 32'(dualCnt), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("contended quiet", 32'({iAck, dAck, mEn}), 32'd0);

    // Instance B: three-cycle read latency, with a single strobe per fetch.
    iReqB = 1'b1; iAddrB = 32'h20;
    @(negedge clk);
    checkOutput("B m_en", 32'(mEnB), 32'd1);
    checkOutput("B m_addr", mAddrB, 32'h20);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("B wait%0d", k), 32'({mEnB, iAckB, dAckB}), 32'd0);
    end
    @(negedge clk);
    checkOutput("B i_ack", 32'({mEnB, iAckB, dAckB}), 32'b010);
    checkOutput("B i_rdata", iRdataB, 32'hC0DE_0020);
    iReqB = 1'b0;
    @(negedge clk);
    checkOutput("B ack clear", 32'(iAckB), 32'd0);
    checkOutput("B i_rdata held", iRdataB, 32'hC0DE_0020);

    // Reset asserted while instance B waits on memory.
    iReqB = 1'b1; iAddrB = 32'h30;
    @(negedge clk);
    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    checkOutput("B rst flags", 32'({iAckB, dAckB, mEnB, mWeB, mMaskB}), 32'd0);
    checkOutput("B rst i_rdata", iRdataB, 32'h0);
    checkOutput("B rst d_rdata", dRdataB, 32'h0);
    checkOutput("B rst m_addr", mAddrB, 32'h0);
    checkOutput("B rst m_wdata", mWdataB, 32'h0);
    rstB  = 1'b0;
    iReqB = 1'b0;
    ackCnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (iAckB || dAckB || mEnB) ackCnt++;
    end
    checkOutput("B no ack after rst", 32'(ackCnt), 32'd0);

    // A fresh fetch after the reset completes with normal timing.
    iReqB = 1'b1; iAddrB = 32'h24;
    ackCycle = 0;
    for (int c = 1; c <= 8 && ackCycle == 0; c++) begin
      @(negedge clk);
      if (iAckB) begin
        ackCycle = c;
        checkOutput("B fresh i_rdata", iRdataB, 32'hC0DE_0024);
      end
    end
    iReqB = 1'b0;
    checkOutput("B fresh ack cycle", 32'(ackCycle), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFail);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its data load/store port.
- Replaces the separate instruction/data memories with one unified memory.
- Sits between the processor top and the memory macro; serializes requests with a req/ack handshake per requester.
- Data has priority by default; a starvation limit guarantees fetch progress.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles from m_en to valid m_rdata (legal range 1..7)
- STARVE_LIM, 4, consecutive data grants allowed while i_req is pending before fetch is forced (legal range 1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched instruction; valid with i_ack, held until next i_ack
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_mask  in  4  byte write enables for a store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid with d_ack, held until next d_ack
- d_ack  out  1  one-cycle completion pulse
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write enable (qualified by m_en)
- m_mask  out  4  memory byte mask (d_mask for stores, 4'b0000 for reads)
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data

Behaviour:
- Reset:
  - All outputs are 0, including i_rdata and d_rdata.
  - FSM goes to IDLE; the latency counter and starvation counter clear.
  - A reset mid-transaction aborts it with no ack issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Winner selection:
    - Only one request present: that requester wins.
    - Both present: data wins, unless starve_cnt == STARVE_LIM, in which case fetch wins.
  - The winner's address, control and data are latched. Go to ISSUE.
- ISSUE:
  - One cycle: m_en=1, with m_addr, m_we, m_mask and m_wdata from the latched values.
  - Store: go to DONE.
  - Read: load lat_cnt = MEM_LAT-1.
    - lat_cnt == 0: go to DONE.
    - Otherwise: go to WAIT.
- WAIT: decrement lat_cnt each cycle; go to DONE when lat_cnt == 0.
- DONE:
  - Read: m_rdata is captured into the winner's rdata register.
  - The winner's ack pulses for exactly one cycle. Go to IDLE.
- Latency:
  - Request seen in IDLE at cycle T: m_en at T+1.
  - Read ack at T+1+MEM_LAT.
  - Store ack at T+2.
  - Minimum spacing between accepted grants: MEM_LAT+2 cycles for reads, 3 cycles for stores.
- Outside ISSUE, m_en=0 and m_we=0; m_addr, m_mask and m_wdata hold their last value.
- Starvation counter:
  - Increments, saturating at STARVE_LIM, when data is granted while i_req=1.
  - Clears on any fetch grant, or when i_req=0 at a grant decision.
- Requesters must hold req and operands stable until ack.
  - If req drops early, the in-flight transaction still completes and acks; the next decision uses current inputs.
- A requester may reassert req in the cycle after its ack; it is sampled in IDLE.
- i_ack and d_ack are never high in the same cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - With both requests present, the grant alternates: it goes to the requester not granted last.
  - The last-grant flag resets to fetch, so the first contended grant goes to data.
  - The starvation counter and STARVE_LIM are unused; the counter is held at 0.
- Undefined: fixed data priority with starvation limit, as above.

Test Plan:
- Fetch only, MEM_LAT=1, i_addr=32'h0000_0010, memory word 32'h0010_0093:
  - m_en at T+1 with m_addr=32'h10.
  - i_ack at T+2 with i_rdata=32'h0010_0093.
  - d_ack stays 0.
- Store then load, d_addr=32'h100, d_wdata=32'hDEAD_BEEF, d_mask=4'b0011:
  - Store: m_we=1 and m_mask=4'b0011 at T+1; d_ack at T+2.
  - Following load: d_rdata=32'h0000_BEEF, given memory preloaded with 0.
- Both requests held continuously, STARVE_LIM=4:
  - Grant order D,D,D,D,I,D,D,D,D,I.
  - Exactly one ack per transaction; never simultaneous acks.
- MEM_LAT=3, fetch at T: m_en at T+1 only, i_ack at T+4; no second m_en before i_ack.
- rst asserted in WAIT:
  - Next cycle all outputs are 0 and no ack occurs.
  - A fresh i_req after reset completes normally.
- With ARB_ROUND_ROBIN_EN, both requests held: grant order D,I,D,I,D,I.
